// File: rtl/mem_access_stage.sv
// RV32I memory-access stage: runs loads/stores against data memory over a
// req/ready/rvalid handshake, aligns load data and registers the WB fields.
module mem_access_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ex_valid,
    input  logic [31:0]           i_ex_result,
    input  logic [31:0]           i_ex_rs2_data,
    input  logic [2:0]            i_ex_funct3,
    input  logic                  i_ex_mem_read,
    input  logic                  i_ex_mem_write,
    input  logic                  i_ex_mem_to_reg,
    input  logic [1:0]            i_ex_rw_sel,
    input  logic [31:0]           i_ex_pc_plus_4,
    input  logic [4:0]            i_ex_rd,
    input  logic                  i_ex_reg_write,
    output logic                  o_ma_stall,
    output logic                  o_dmem_req,
    output logic                  o_dmem_we,
    output logic [ADDR_WIDTH-1:0] o_dmem_addr,
    output logic [31:0]           o_dmem_wdata,
    output logic [3:0]            o_dmem_be,
    input  logic                  i_dmem_ready,
    input  logic                  i_dmem_rvalid,
    input  logic [31:0]           i_dmem_rdata,
    output logic                  o_ma_valid,
    output logic [31:0]           o_ma_result,
    output logic [31:0]           o_ma_read_data,
    output logic [31:0]           o_ma_pc_plus_4,
    output logic                  o_ma_mem_to_reg,
    output logic [1:0]            o_ma_rw_sel,
    output logic [4:0]            o_ma_rd,
    output logic                  o_ma_reg_write,
    output logic                  o_ma_misaligned
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_RD = 2'd2} state_t;

    state_t                  state_q, state_d;
    logic                    req_q, req_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              be_q, be_d;
    logic                    valid_q, valid_d;
    logic [31:0]             result_q, result_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [31:0]             pc4_q, pc4_d;
    logic                    m2r_q, m2r_d;
    logic [1:0]              rws_q, rws_d;
    logic [4:0]              rd_q, rd_d;
    logic                    rw_q, rw_d;
    logic                    mis_q, mis_d;
    logic                    load_q, load_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [1:0]              lane_q, lane_d;

    logic                    ex_mem_op, ex_mis, ex_launch;
    logic [3:0]              st_be;
    logic [31:0]             st_wdata;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [31:0]             ld_data;

    // funct3[1:0]: 00 byte, 01 half, 1x word (unknown sizes fall back to word)
    assign ex_mem_op = i_ex_mem_read | i_ex_mem_write;
    assign ex_mis    = ex_mem_op &
                       (((i_ex_funct3[1:0] == 2'b01) & i_ex_result[0]) |
                        (i_ex_funct3[1] & (i_ex_result[1:0] != 2'b00)));
    assign ex_launch = i_ex_valid & ex_mem_op & ~ex_mis;

    always_comb begin
        case (i_ex_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << i_ex_result[1:0];
                st_wdata = {4{i_ex_rs2_data[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {i_ex_result[1], 1'b0};
                st_wdata = {2{i_ex_rs2_data[15:0]}};
            end
            default: begin
                st_be    = 4'hF;
                st_wdata = i_ex_rs2_data;
            end
        endcase
    end

    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = i_dmem_rdata[7:0];
            2'd1:    ld_byte = i_dmem_rdata[15:8];
            2'd2:    ld_byte = i_dmem_rdata[23:16];
            default: ld_byte = i_dmem_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = i_dmem_rdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ex_launch) state_d = REQ;
            REQ:     if (i_dmem_ready) state_d = load_q ? WAIT_RD : IDLE;
            WAIT_RD: if (i_dmem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A misaligned op retires without a transaction, so EX may advance at once.
    always_comb begin
        o_ma_stall = 1'b0;
        case (state_q)
            IDLE:    o_ma_stall = ex_launch;
            REQ:     o_ma_stall = ~(i_dmem_ready & ~load_q);
            WAIT_RD: o_ma_stall = ~i_dmem_rvalid;
            default: o_ma_stall = 1'b0;
        endcase
    end

    always_comb begin
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        valid_d  = 1'b0;
        result_d = result_q;
        rdata_d  = rdata_q;
        pc4_d    = pc4_q;
        m2r_d    = m2r_q;
        rws_d    = rws_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        mis_d    = mis_q;
        load_d   = load_q;
        funct3_d = funct3_q;
        lane_d   = lane_q;
        case (state_q)
            IDLE: if (i_ex_valid) begin
                result_d = i_ex_result;
                rdata_d  = 32'h0;
                pc4_d    = i_ex_pc_plus_4;
                m2r_d    = i_ex_mem_to_reg;
                rws_d    = i_ex_rw_sel;
                rd_d     = i_ex_rd;
                rw_d     = i_ex_reg_write & ~ex_mis;
                mis_d    = ex_mis;
                load_d   = i_ex_mem_read;
                funct3_d = i_ex_funct3;
                lane_d   = i_ex_result[1:0];
                if (ex_launch) begin
                    req_d   = 1'b1;
                    we_d    = ~i_ex_mem_read;
                    addr_d  = {i_ex_result[ADDR_WIDTH-1:2], 2'b00};
                    wdata_d = st_wdata;
                    be_d    = st_be;
                end else begin
                    valid_d = 1'b1;
                end
            end
            REQ: if (i_dmem_ready) begin
                req_d   = 1'b0;
                valid_d = ~load_q;
            end
            WAIT_RD: if (i_dmem_rvalid) begin
                rdata_d = ld_data;
                valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            be_q     <= 4'h0;
            valid_q  <= 1'b0;
            result_q <= 32'h0;
            rdata_q  <= 32'h0;
            pc4_q    <= 32'h0;
            m2r_q    <= 1'b0;
            rws_q    <= 2'b0;
            rd_q     <= 5'h0;
            rw_q     <= 1'b0;
            mis_q    <= 1'b0;
            load_q   <= 1'b0;
            funct3_q <= 3'b0;
            lane_q   <= 2'b0;
        end else begin
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            rdata_q  <= rdata_d;
            pc4_q    <= pc4_d;
            m2r_q    <= m2r_d;
            rws_q    <= rws_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            mis_q    <= mis_d;
            load_q   <= load_d;
            funct3_q <= funct3_d;
            lane_q   <= lane_d;
        end
    end

    assign o_dmem_req      = req_q;
    assign o_dmem_we       = we_q;
    assign o_dmem_addr     = addr_q;
    assign o_dmem_wdata    = wdata_q;
    assign o_dmem_be       = be_q;
    assign o_ma_valid      = valid_q;
    assign o_ma_result     = result_q;
    assign o_ma_read_data  = rdata_q;
    assign o_ma_pc_plus_4  = pc4_q;
    assign o_ma_mem_to_reg = m2r_q;
    assign o_ma_rw_sel     = rws_q;
    assign o_ma_rd         = rd_q;
    assign o_ma_reg_write  = rw_q;
    assign o_ma_misaligned = mis_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: expected WB records are queued at issue
// and compared against each o_ma_valid pulse; handshake timing checked inline.
module tb_mem_access_stage;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_ex_valid = 1'b0;
    logic [31:0] i_ex_result = '0, i_ex_rs2_data = '0, i_ex_pc_plus_4 = '0;
    logic [2:0]  i_ex_funct3 = '0;
    logic        i_ex_mem_read = 1'b0, i_ex_mem_write = 1'b0, i_ex_mem_to_reg = 1'b0;
    logic [1:0]  i_ex_rw_sel = '0;
    logic [4:0]  i_ex_rd = '0;
    logic        i_ex_reg_write = 1'b0;
    logic        i_dmem_ready = 1'b0, i_dmem_rvalid = 1'b0;
    logic [31:0] i_dmem_rdata = '0;

    logic        o_ma_stall, o_dmem_req, o_dmem_we, o_ma_valid;
    logic [31:0] o_dmem_addr, o_dmem_wdata, o_ma_result, o_ma_read_data, o_ma_pc_plus_4;
    logic [3:0]  o_dmem_be;
    logic        o_ma_mem_to_reg, o_ma_reg_write, o_ma_misaligned;
    logic [1:0]  o_ma_rw_sel;
    logic [4:0]  o_ma_rd;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] rdat;
        logic [31:0] pc4;
        logic        m2r;
        logic [1:0]  rws;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
    } wb_t;

    wb_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_valid  = 0;

    mem_access_stage #(.ADDR_WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_ex_valid(i_ex_valid),
        .i_ex_result(i_ex_result), .i_ex_rs2_data(i_ex_rs2_data),
        .i_ex_funct3(i_ex_funct3), .i_ex_mem_read(i_ex_mem_read),
        .i_ex_mem_write(i_ex_mem_write), .i_ex_mem_to_reg(i_ex_mem_to_reg),
        .i_ex_rw_sel(i_ex_rw_sel), .i_ex_pc_plus_4(i_ex_pc_plus_4),
        .i_ex_rd(i_ex_rd), .i_ex_reg_write(i_ex_reg_write),
        .o_ma_stall(o_ma_stall), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
        .i_dmem_ready(i_dmem_ready), .i_dmem_rvalid(i_dmem_rvalid),
        .i_dmem_rdata(i_dmem_rdata), .o_ma_valid(o_ma_valid),
        .o_ma_result(o_ma_result), .o_ma_read_data(o_ma_read_data),
        .o_ma_pc_plus_4(o_ma_pc_plus_4), .o_ma_mem_to_reg(o_ma_mem_to_reg),
        .o_ma_rw_sel(o_ma_rw_sel), .o_ma_rd(o_ma_rd),
        .o_ma_reg_write(o_ma_reg_write), .o_ma_misaligned(o_ma_misaligned)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge i_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge i_clk);
    endtask

    task automatic ex(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                      input logic [31:0] res, input logic [31:0] rs2, input logic [31:0] pc4,
                      input logic m2r, input logic [1:0] rws, input logic [4:0] rd,
                      input logic rw);
        i_ex_valid = 1'b1;      i_ex_mem_read = rd_en;  i_ex_mem_write = wr_en;
        i_ex_funct3 = f3;       i_ex_result = res;      i_ex_rs2_data = rs2;
        i_ex_pc_plus_4 = pc4;   i_ex_mem_to_reg = m2r;  i_ex_rw_sel = rws;
        i_ex_rd = rd;           i_ex_reg_write = rw;
    endtask

    task automatic push(input logic [31:0] res, input logic [31:0] rdat, input logic [31:0] pc4,
                        input logic m2r, input logic [1:0] rws, input logic [4:0] rd,
                        input logic rw, input logic mis);
        wb_t e;
        e.res = res; e.rdat = rdat; e.pc4 = pc4; e.m2r = m2r;
        e.rws = rws; e.rd = rd; e.rw = rw; e.mis = mis;
        sb.push_back(e);
    endtask

    // Scoreboard: every retirement must match the oldest queued expectation
    always @(negedge i_clk) begin
        if (o_ma_valid === 1'b1) begin
            n_valid++;
            if (sb.size() == 0) begin
                chk("sb_pending", 32'(sb.size()), 32'd1);
            end else begin
                wb_t e;
                e = sb.pop_front();
                chk("wb_result", o_ma_result, e.res);
                chk("wb_read_data", o_ma_read_data, e.rdat);
                chk("wb_pc_plus_4", o_ma_pc_plus_4, e.pc4);
                chk("wb_ctl", {22'h0, o_ma_mem_to_reg, o_ma_rw_sel, o_ma_rd, o_ma_reg_write, o_ma_misaligned},
                    {22'h0, e.m2r, e.rws, e.rd, e.rw, e.mis});
            end
        end
    end

    initial begin
        // Reset state
        next(); next(); smp();
        chk("rst_valid", o_ma_valid, 0);   chk("rst_req", o_dmem_req, 0);
        chk("rst_stall", o_ma_stall, 0);   chk("rst_result", o_ma_result, 0);
        chk("rst_be", o_dmem_be, 0);       chk("rst_rd", o_ma_rd, 0);
        next(); i_rst = 1'b0;

        // ALU op retires with latency 1
        next(); ex(0, 0, 3'b000, 32'h1234, 32'h0, 32'h44, 0, 2'd0, 5'd5, 1);
        push(32'h1234, 32'h0, 32'h44, 0, 2'd0, 5'd5, 1, 0);
        smp(); chk("add_stall", o_ma_stall, 0);
        next(); i_ex_valid = 1'b0;
        smp(); chk("add_valid", o_ma_valid, 1); chk("add_noreq", o_dmem_req, 0);
        next(); smp(); chk("add_bubble", o_ma_valid, 0);

        // LB from lane 3, sign-extended
        next(); ex(1, 0, 3'b000, 32'h103, 32'h0, 32'h48, 1, 2'd0, 5'd7, 1);
        push(32'h103, 32'hFFFF_FF80, 32'h48, 1, 2'd0, 5'd7, 1, 0);
        smp(); chk("lb_stall_idle", o_ma_stall, 1);
        next(); i_dmem_ready = 1'b1;
        smp(); chk("lb_req", o_dmem_req, 1); chk("lb_addr", o_dmem_addr, 32'h100);
        chk("lb_we", o_dmem_we, 0);       chk("lb_stall_req", o_ma_stall, 1);
        next(); i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h80AA_BBCC;
        smp(); chk("lb_stall_drop", o_ma_stall, 0); chk("lb_valid_early", o_ma_valid, 0);
        next(); i_dmem_rvalid = 1'b0; i_ex_valid = 1'b0;
        smp(); chk("lb_valid", o_ma_valid, 1); chk("lb_req_done", o_dmem_req, 0);

        // SH to upper half, ready held low for 3 cycles
        next(); ex(0, 1, 3'b001, 32'h202, 32'h0000_BEEF, 32'h4C, 0, 2'd0, 5'd0, 0);
        push(32'h202, 32'h0, 32'h4C, 0, 2'd0, 5'd0, 0, 0);
        smp(); chk("sh_stall_idle", o_ma_stall, 1);
        for (int i = 0; i < 3; i++) begin
            next(); smp();
            chk("sh_req_hold", o_dmem_req, 1);  chk("sh_be", o_dmem_be, 4'b1100);
            chk("sh_wdata", o_dmem_wdata, 32'hBEEF_BEEF); chk("sh_we", o_dmem_we, 1);
            chk("sh_addr", o_dmem_addr, 32'h200); chk("sh_stall_wait", o_ma_stall, 1);
        end
        next(); i_dmem_ready = 1'b1;
        smp(); chk("sh_stall_done", o_ma_stall, 0); chk("sh_valid_early", o_ma_valid, 0);
        next(); i_dmem_ready = 1'b0; i_ex_valid = 1'b0;
        smp(); chk("sh_valid", o_ma_valid, 1); chk("sh_req_done", o_dmem_req, 0);

        // SB to lane 1, ready immediately
        next(); ex(0, 1, 3'b000, 32'h501, 32'h1234_5678, 32'h50, 0, 2'd0, 5'd0, 0);
        push(32'h501, 32'h0, 32'h50, 0, 2'd0, 5'd0, 0, 0);
        next(); i_dmem_ready = 1'b1;
        smp(); chk("sb_be", o_dmem_be, 4'b0010); chk("sb_wdata", o_dmem_wdata, 32'h7878_7878);
        chk("sb_addr", o_dmem_addr, 32'h500);    chk("sb_stall", o_ma_stall, 0);
        next(); i_dmem_ready = 1'b0; i_ex_valid = 1'b0;
        smp(); chk("sb_valid", o_ma_valid, 1);

        // Misaligned LW: no request, reg_write suppressed
        next(); ex(1, 0, 3'b010, 32'h301, 32'h0, 32'h54, 1, 2'd0, 5'd9, 1);
        push(32'h301, 32'h0, 32'h54, 1, 2'd0, 5'd9, 0, 1);
        next(); i_ex_valid = 1'b0;
        smp(); chk("mis_valid", o_ma_valid, 1); chk("mis_flag", o_ma_misaligned, 1);
        chk("mis_noreq", o_dmem_req, 0);
        next(); smp(); chk("mis_noreq2", o_dmem_req, 0); chk("mis_bubble", o_ma_valid, 0);

        // LH from upper half, sign-extended
        next(); ex(1, 0, 3'b001, 32'h602, 32'h0, 32'h58, 1, 2'd0, 5'd12, 1);
        push(32'h602, 32'hFFFF_8001, 32'h58, 1, 2'd0, 5'd12, 1, 0);
        next(); i_dmem_ready = 1'b1;
        smp(); chk("lh_addr", o_dmem_addr, 32'h600);
        next(); i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h8001_7FFF;
        next(); i_dmem_rvalid = 1'b0; i_ex_valid = 1'b0;
        smp(); chk("lh_valid", o_ma_valid, 1);

        // Reset while waiting for read data; the late rvalid must be ignored
        next(); ex(1, 0, 3'b010, 32'h400, 32'h0, 32'h5C, 1, 2'd0, 5'd3, 1);
        next(); i_dmem_ready = 1'b1;
        next(); i_dmem_ready = 1'b0; i_ex_valid = 1'b0; i_rst = 1'b1;
        smp(); chk("rst_wait_stall", o_ma_stall, 1);
        next(); i_rst = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h1234_5678;
        smp(); chk("rstw_valid", o_ma_valid, 0); chk("rstw_req", o_dmem_req, 0);
        chk("rstw_stall", o_ma_stall, 0);        chk("rstw_result", o_ma_result, 0);
        chk("rstw_rd", o_ma_rd, 0);              chk("rstw_be", o_dmem_be, 0);
        next(); i_dmem_rvalid = 1'b0;
        smp(); chk("rstw_ignored", o_ma_valid, 0); chk("rstw_rdata", o_ma_read_data, 0);

        // LBU followed back-to-back by an ALU op
        next(); ex(1, 0, 3'b100, 32'h7, 32'h0, 32'h60, 1, 2'd0, 5'd10, 1);
        push(32'h7, 32'h0000_00A1, 32'h60, 1, 2'd0, 5'd10, 1, 0);
        next(); i_dmem_ready = 1'b1;
        next(); i_dmem_ready = 1'b0;
        smp(); chk("lbu_stall_wait", o_ma_stall, 1);
        next(); i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hA1B2_C3D4;
        smp(); chk("lbu_stall_drop", o_ma_stall, 0);
        next(); i_dmem_rvalid = 1'b0;
        ex(0, 0, 3'b000, 32'h5555, 32'h0, 32'h64, 0, 2'd1, 5'd11, 1);
        push(32'h5555, 32'h0, 32'h64, 0, 2'd1, 5'd11, 1, 0);
        smp(); chk("lbu_valid", o_ma_valid, 1); chk("add2_stall", o_ma_stall, 0);
        next(); i_ex_valid = 1'b0;
        smp(); chk("add2_valid", o_ma_valid, 1);
        next(); smp(); chk("add2_once", o_ma_valid, 0);

        repeat (3) next();
        smp();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("retire_count", 32'(n_valid), 32'd8);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
